ddr_rw_test_gen: RTL and testbench

- User-side traffic generator/checker that sits directly upstream of axi_ddr_ctrl.
- Drives its write-FIFO port (wr_en/wr_data) with a deterministic 16-bit pattern, then drains its read-FIFO port (rd_en/rd_data/rd_valid) and compares every word against the regenerated pattern.
- Reports done/pass/error count. Used for board bring-up and regression of the DDR path.
- Single clock: top level ties axi_ddr_ctrl wr_clk and rd_clk to this clk.

---
 rtl/ddr_test_pkg.sv | 24 ++
 rtl/ddr_pattern_gen.sv | 40 ++++
 rtl/ddr_rw_test_gen.sv | 178 +++++++++++++++++
 tb/tb_ddr_rw_test_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR read/write traffic generator.
// State encoding, pattern-generator constants and counter width.
package ddr_test_pkg;

  localparam int unsigned CNT_W = 16;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1:
  // the feedback bit is the XOR of register bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_WRITE,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] w);
    return {^(w & LFSR_TAPS), w[15:1]};
  endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Deterministic 16-bit pattern source shared by the writer and the checker.
// DDR_TEST_LFSR_EN selects a 16-bit Fibonacci LFSR; otherwise an
// incrementing counter starting at SEED.
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        adv,
  output logic [15:0] word
);

  logic [15:0] word_q, word_d;

  // Next pattern word: reload on clr, step on adv.
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = SEED;
    end else if (adv) begin
`ifdef DDR_TEST_LFSR_EN
      word_d = lfsr_next(word_q);
`else
      word_d = word_q + 16'd1;
`endif
    end
  end

  // Pattern register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= SEED;
    else        word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/ddr_rw_test_gen.sv
// DDR traffic generator/checker placed upstream of axi_ddr_ctrl.
// Writes TOTAL_WORDS pattern words, waits, reads them back and compares.
// Optional macro DDR_TEST_LFSR_EN selects the LFSR pattern (see
// ddr_pattern_gen).
module ddr_rw_test_gen
  import ddr_test_pkg::*;
#(
  parameter logic [29:0] BEG_ADDR    = 30'd0,
  parameter int unsigned TOTAL_WORDS = 4096,
  parameter logic [7:0]  BURST_LEN   = 8'd31,
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned WAIT_CYC    = 1024,
  parameter logic [15:0] SEED        = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        wr_rst,
  output logic        rd_rst,
  output logic [29:0] wr_beg_addr,
  output logic [29:0] wr_end_addr,
  output logic [7:0]  wr_burst_len,
  output logic [29:0] rd_beg_addr,
  output logic [29:0] rd_end_addr,
  output logic [7:0]  rd_burst_len,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        rd_mem_enable,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_idx
);

  localparam logic [29:0]      END_ADDR  = 30'(BEG_ADDR + 30'(TOTAL_WORDS * 2));
  localparam logic [CNT_W-1:0] TOTAL_W   = CNT_W'(TOTAL_WORDS);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(TOTAL_WORDS - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] checked_q, checked_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      first_q, first_d;
  logic             rd_en_q;
  logic             gen_clr, wgen_adv, cgen_adv;
  logic [15:0]      wgen_word, cgen_word;

  ddr_pattern_gen #(.SEED(SEED)) u_wr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (gen_clr),
    .adv  (wgen_adv),
    .word (wgen_word)
  );

  ddr_pattern_gen #(.SEED(SEED)) u_chk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (gen_clr),
    .adv  (cgen_adv),
    .word (cgen_word)
  );

  // Sequencing, read issue and compare bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    checked_d = checked_q;
    err_d     = err_q;
    first_d   = first_q;
    gen_clr   = 1'b0;
    wgen_adv  = 1'b0;
    cgen_adv  = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      end
      ST_RST: begin
        issued_d  = '0;
        checked_d = '0;
        err_d     = '0;
        first_d   = '0;
        gen_clr   = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        wgen_adv = 1'b1;
        if (cnt_q == WORD_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        rd_en = rd_valid && (issued_q < TOTAL_W);
        if (rd_en) issued_d = issued_q + 1'b1;
        // Compare is driven by the registered request, so a word already
        // requested is checked even if rd_valid drops in the same cycle.
        if (rd_en_q) begin
          cgen_adv  = 1'b1;
          checked_d = checked_q + 1'b1;
          if (rd_data != cgen_word) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_d = checked_q;
          end
          if (checked_q == WORD_LAST) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      issued_q  <= '0;
      checked_q <= '0;
      err_q     <= '0;
      first_q   <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      issued_q  <= issued_d;
      checked_q <= checked_d;
      err_q     <= err_d;
      first_q   <= first_d;
      rd_en_q   <= rd_en;
    end
  end

  assign wr_rst        = (state_q == ST_IDLE) || (state_q == ST_RST);
  assign rd_rst        = wr_rst;
  assign wr_en         = (state_q == ST_WRITE);
  assign wr_data       = wgen_word;
  assign rd_mem_enable = (state_q == ST_READ) || (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_q == 16'd0);
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;

  assign wr_beg_addr  = BEG_ADDR;
  assign wr_end_addr  = END_ADDR;
  assign wr_burst_len = BURST_LEN;
  assign rd_beg_addr  = BEG_ADDR;
  assign rd_end_addr  = END_ADDR;
  assign rd_burst_len = BURST_LEN;

endmodule

// File: tb/tb_ddr_rw_test_gen.sv
// Self-checking bench for ddr_rw_test_gen with a behavioural
// controller/memory/FIFO model and randomized read-side gaps and corruption.
module tb_ddr_rw_test_gen;

  localparam logic [29:0] BA = 30'h100;
  localparam int unsigned TW = 256;
  localparam logic [7:0]  BL = 8'd7;
  localparam int unsigned RC = 16;
  localparam int unsigned WC = 32;
`ifdef DDR_TEST_LFSR_EN
  localparam logic [15:0] SD = 16'hACE1;
`else
  localparam logic [15:0] SD = 16'h0001;
`endif

  logic        clk, rst_n, start;
  logic        wr_rst, rd_rst, wr_en, rd_mem_enable, rd_en, rd_valid;
  logic        busy, done, pass;
  logic [29:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
  logic [7:0]  wr_burst_len, rd_burst_len;
  logic [15:0] wr_data, rd_data, err_cnt, first_err_idx;

  ddr_rw_test_gen #(
    .BEG_ADDR(BA), .TOTAL_WORDS(TW), .BURST_LEN(BL),
    .RST_CYC(RC), .WAIT_CYC(WC), .SEED(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_rst(wr_rst), .rd_rst(rd_rst),
    .wr_beg_addr(wr_beg_addr), .wr_end_addr(wr_end_addr), .wr_burst_len(wr_burst_len),
    .rd_beg_addr(rd_beg_addr), .rd_end_addr(rd_end_addr), .rd_burst_len(rd_burst_len),
    .wr_en(wr_en), .wr_data(wr_data), .rd_mem_enable(rd_mem_enable),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [15:0] exp_pat [TW];
  logic [15:0] flip    [TW];
  logic [15:0] mem     [TW];
  logic [15:0] fifo    [$];
  int unsigned wr_ptr = 0, pf_ptr = 0, rd_pops = 0;
  logic        rd_take = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural write FIFO + DDR memory + prefetching read FIFO.
  initial begin
    rd_valid = 1'b0;
    rd_data  = 16'd0;
    forever begin
      @(negedge clk);
      if (wr_rst) begin
        wr_ptr = 0;
      end else if (wr_en && wr_ptr < TW) begin
        mem[wr_ptr] = wr_data;
        wr_ptr++;
      end
      if (rd_rst) begin
        fifo.delete();
        pf_ptr  = 0;
        rd_take = 1'b0;
      end else begin
        if (rd_take) begin
          if (fifo.size() > 0) rd_data = fifo.pop_front();
          rd_pops++;
        end
        if (rd_mem_enable && pf_ptr < wr_ptr && fifo.size() < 64 &&
            $urandom_range(3) != 0) begin
          fifo.push_back(mem[pf_ptr] ^ flip[pf_ptr]);
          pf_ptr++;
        end
      end
      rd_valid = (fifo.size() != 0);
      #1;
      rd_take = rd_en;
    end
  end

  task automatic exp_errors(output int unsigned n, output int unsigned first);
    n = 0;
    first = 0;
    for (int unsigned i = 0; i < TW; i++) begin
      if (flip[i] != 16'd0) begin
        if (n == 0) first = i;
        n++;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_test(input string name, input bit poke_start);
    int unsigned n_err, first, wr_n, rst_n_cyc, pops0;
    logic [15:0] lfsr_ref [3];
    lfsr_ref[0] = 16'hACE1; lfsr_ref[1] = 16'h5670; lfsr_ref[2] = 16'hAB38;
    exp_errors(n_err, first);
    wr_n = 0;
    rst_n_cyc = 0;
    pops0 = rd_pops;
    pulse_start();
    for (int unsigned cyc = 0; cyc < 5000 && !done; cyc++) begin
      start = 1'b0;
      if (wr_rst && busy) rst_n_cyc++;
      if (wr_en) begin
        if (wr_n < TW) chk({name, "_wr_data"}, wr_data, exp_pat[wr_n]);
`ifdef DDR_TEST_LFSR_EN
        if (wr_n < 3) chk({name, "_lfsr_const"}, wr_data, lfsr_ref[wr_n]);
`endif
        wr_n++;
        if (poke_start && wr_n == 50) start = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_rst_cycles"}, rst_n_cyc, RC);
    chk({name, "_wr_count"}, wr_n, TW);
    chk({name, "_err_cnt"}, err_cnt, n_err);
    chk({name, "_first_err"}, first_err_idx, first);
    chk({name, "_pass"}, pass, (n_err == 0));
    chk({name, "_rd_mem_en"}, rd_mem_enable, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_rd_count"}, rd_pops - pops0, TW);
  endtask

  initial begin
    logic [15:0] w;
    w = SD;
    for (int unsigned i = 0; i < TW; i++) begin
      exp_pat[i] = w;
`ifdef DDR_TEST_LFSR_EN
      w = {w[0] ^ w[2] ^ w[3] ^ w[5], w[15:1]};
`else
      w = w + 16'd1;
`endif
      flip[i] = 16'd0;
    end

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_rst", wr_rst, 1'b1);
    chk("rst_rd_rst", rd_rst, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_rd_mem_en", rd_mem_enable, 1'b0);
    chk("rst_wr_data", wr_data, SD);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    chk("rst_first_err", first_err_idx, 16'd0);
    chk("wr_beg_addr", wr_beg_addr, 30'h100);
    chk("wr_end_addr", wr_end_addr, 30'h300);
    chk("rd_beg_addr", rd_beg_addr, 30'h100);
    chk("rd_end_addr", rd_end_addr, 30'h300);
    chk("wr_burst_len", wr_burst_len, 8'd7);
    chk("rd_burst_len", rd_burst_len, 8'd7);
    @(posedge clk); #1 rst_n = 1'b1;

    // Clean run.
    run_test("clean", 1'b0);

    // Two single-bit corruptions.
    flip[10]  = 16'h0001;
    flip[200] = 16'h0001;
    run_test("two_err", 1'b0);

    // Random corruption pattern.
    for (int unsigned i = 0; i < TW; i++)
      flip[i] = ($urandom_range(3) == 0) ? 16'($urandom_range(1, 16'hFFFF)) : 16'd0;
    run_test("rand_err", 1'b0);

    // Everything corrupted except word 0.
    for (int unsigned i = 0; i < TW; i++) flip[i] = (i == 0) ? 16'd0 : 16'h8000;
    run_test("all_err", 1'b0);

    // start pulsed mid-WRITE must be ignored.
    for (int unsigned i = 0; i < TW; i++) flip[i] = 16'd0;
    run_test("start_in_write", 1'b1);

    // rst_n during READ with corrupted data, then a clean rerun.
    for (int unsigned i = 0; i < TW; i++) flip[i] = 16'h00FF;
    pulse_start();
    for (int unsigned i = 0; i < 5000 && (rd_pops < 20 + 5 * TW); i++) @(posedge clk);
    #1;
    chk("mid_read_reached", (rd_pops >= 20 + 5 * TW), 1'b1);
    chk("mid_read_errs_seen", (err_cnt != 16'd0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_rst", wr_rst, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err_cnt", err_cnt, 16'd0);
    chk("arst_rd_mem_en", rd_mem_enable, 1'b0);
    chk("arst_rd_en", rd_en, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int unsigned i = 0; i < TW; i++) flip[i] = 16'd0;
    run_test("after_reset", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
